// File: rtl/instr_encoder_loader.sv
// Instruction assembler/loader: packs decoded fields into 16-bit words, buffers them
// in a small FIFO and streams them to instruction memory at consecutive byte addresses.
module instr_encoder_loader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [3:0]        rs,
  input  logic [3:0]        rt,
  input  logic [3:0]        rd,
  input  logic [15:0]       imm,
  input  logic [2:0]        cc,
  output logic              mem_wr_en,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W-1:0] word_count,
  output logic              done,
  output logic              err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StDone, StErr} state_e;

  state_e            r_state;
  logic [15:0]       r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [CntW-1:0]   r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_wcount;
  logic              r_done;
  logic              r_err;

  logic [15:0]       w_word;
  logic              w_legal;
  logic              w_accept;
  logic              w_push;
  logic              w_bad;
  logic              w_pop;

  // Ready depends only on registered state so mem_ready never reaches in_ready.
  assign in_ready   = (r_state == StRun) && (r_cnt != CntW'(FIFO_DEPTH));
  assign mem_wr_en  = (r_cnt != '0) && ((r_state == StRun) || (r_state == StDrain));
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_mem[r_rptr];
  assign word_count = r_wcount;
  assign done       = r_done;
  assign err        = r_err;

  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;
  assign w_bad    = w_accept && !w_legal;
  assign w_pop    = mem_wr_en && mem_ready;

  // Field packing and immediate range check per opcode class.
  always_comb begin
    w_word  = 16'hF000;
    w_legal = 1'b1;
    case (opcode)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: w_word = {opcode, rd, rs, rt};
      4'h4, 4'h5, 4'h6: begin
        w_word  = {opcode, rd, rs, imm[3:0]};
        w_legal = ~|imm[15:4];
      end
      4'h8, 4'h9: begin
        // Signed 4-bit offset: upper bits must be a pure sign extension.
        w_word  = {opcode, rt, rs, imm[3:0]};
        w_legal = (&imm[15:3]) | ~|imm[15:3];
      end
      4'hA, 4'hB: begin
        w_word  = {opcode, rd, imm[7:0]};
        w_legal = ~|imm[15:8];
      end
      4'hC: begin
        w_word  = {opcode, cc, imm[8:0]};
        w_legal = (&imm[15:8]) | ~|imm[15:8];
      end
      4'hD:    w_word = {opcode, cc, 1'b0, rs, 4'h0};
      4'hE:    w_word = {opcode, rd, 8'h00};
      default: w_word = 16'hF000;
    endcase
  end

  // FIFO storage: write the encoded word at the tail on every legal accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // Control FSM plus FIFO pointers, write address and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wcount <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rptr   <= r_rptr + PtrW'(1);
        r_addr   <= r_addr + ADDR_W'(2);
        r_wcount <= r_wcount + ADDR_W'(1);
      end
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CntW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CntW'(1);

      case (r_state)
        StIdle, StDone, StErr: begin
          if (start) begin
            r_state  <= StRun;
            r_addr   <= base_addr & ~ADDR_W'(1);
            r_wcount <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
          end
        end
        StRun: begin
          if (w_bad) begin
            // Drop everything still queued; completed writes stay in memory.
            r_state <= StErr;
            r_err   <= 1'b1;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
          end else if (w_push && (opcode == 4'hF)) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          // HLT is the last queued word, so the final pop is its write.
          if (w_pop && (r_cnt == CntW'(1))) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  rd;
    logic [15:0] imm;
    logic [2:0]  cc;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [3:0]  rs = '0;
  logic [3:0]  rt = '0;
  logic [3:0]  rd = '0;
  logic [15:0] imm = '0;
  logic [2:0]  cc = '0;
  logic        mem_wr_en;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] word_count;
  logic        done;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  int          to_cnt = 0;
  bit          rand_ready = 1'b0;
  logic [15:0] wa_q[$];
  logic [15:0] wd_q[$];

  instr_encoder_loader #(.FIFO_DEPTH(4), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .imm(imm), .cc(cc), .mem_wr_en(mem_wr_en), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Record every write that will complete at the coming rising edge.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1 && mem_ready === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
  end

  // Reference encoder written from the field rules with integer arithmetic.
  function automatic void model(input ins_t i, output logic [15:0] w, output bit legal);
    int s, u, b, op;
    s  = int'($signed(i.imm));
    u  = int'(i.imm);
    op = int'(i.op);
    b  = op * 4096;
    legal = 1'b1;
    if (op <= 3 || op == 7) w = 16'(b + int'(i.rd) * 256 + int'(i.rs) * 16 + int'(i.rt));
    else if (op >= 4 && op <= 6) begin
      legal = (u <= 15);
      w = 16'(b + int'(i.rd) * 256 + int'(i.rs) * 16 + u % 16);
    end else if (op == 8 || op == 9) begin
      legal = (s >= -8 && s <= 7);
      w = 16'(b + int'(i.rt) * 256 + int'(i.rs) * 16 + (s & 15));
    end else if (op == 10 || op == 11) begin
      legal = (u <= 255);
      w = 16'(b + int'(i.rd) * 256 + u % 256);
    end else if (op == 12) begin
      legal = (s >= -256 && s <= 255);
      w = 16'(b + int'(i.cc) * 512 + (s & 511));
    end else if (op == 13) w = 16'(b + int'(i.cc) * 512 + int'(i.rs) * 16);
    else if (op == 14) w = 16'(b + int'(i.rd) * 256);
    else w = 16'hF000;
  endfunction

  function automatic ins_t mk(input int op, input int r_s, input int r_t, input int r_d,
                              input int im, input int c);
    ins_t i;
    i.op = 4'(op); i.rs = 4'(r_s); i.rt = 4'(r_t); i.rd = 4'(r_d);
    i.imm = 16'(im); i.cc = 3'(c);
    return i;
  endfunction

  // Random instruction that is legal and not HLT.
  function automatic ins_t rand_legal();
    ins_t i;
    i = mk($urandom_range(0, 14), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 65535), $urandom_range(0, 7));
    if (i.op >= 4 && i.op <= 6) i.imm = 16'($urandom_range(0, 15));
    else if (i.op == 8 || i.op == 9) i.imm = 16'($urandom_range(0, 15)) - 16'd8;
    else if (i.op == 10 || i.op == 11) i.imm = 16'($urandom_range(0, 255));
    else if (i.op == 12) i.imm = 16'($urandom_range(0, 511)) - 16'd256;
    return i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; rand_ready = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic do_start(input logic [15:0] a);
    start = 1'b1;
    base_addr = a;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input ins_t i);
    int n = 0;
    opcode = i.op; rs = i.rs; rt = i.rt; rd = i.rd; imm = i.imm; cc = i.cc;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) to_cnt++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) to_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0000", mem_wdata); end
    checks++; if (word_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", word_count); end
    checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b want 00", {done, err}); end
  endtask

  task automatic test_stream();
    logic [15:0] ea[3] = '{16'h0010, 16'h0012, 16'h0014};
    logic [15:0] ed[3] = '{16'h0312, 16'hA45A, 16'hF000};
    int n = 0;
    do_reset();
    mem_ready = 1'b1;
    do_start(16'h0010);
    send(mk(0, 1, 2, 3, 0, 0));
    send(mk(10, 0, 0, 4, 'h5A, 0));
    send(mk(15, 0, 0, 0, 0, 0));
    while (wa_q.size() < 3 && n < 50) begin tick(); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stream_done_timing: got %b want 1", done); end
    checks++; if (wa_q.size() != 3) begin errors++; $display("FAIL stream_nwrites: got %0d want 3", wa_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wa_q.size() || wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
        errors++;
        $display("FAIL stream_write%0d: got %h@%h want %h@%h", i,
                 (i < wd_q.size()) ? wd_q[i] : 16'hxxxx, (i < wa_q.size()) ? wa_q[i] : 16'hxxxx, ed[i], ea[i]);
      end
    end
    checks++; if (word_count !== 16'd3) begin errors++; $display("FAIL stream_count: got %0d want 3", word_count); end
    checks++; if (to_cnt != 0) begin errors++; $display("FAIL stream_timeout: got %0d want 0", to_cnt); to_cnt = 0; end
  endtask

  task automatic test_branch();
    logic [15:0] ed[3] = '{16'hC5FD, 16'hDE50, 16'hE700};
    do_reset();
    mem_ready = 1'b1;
    do_start(16'h0100);
    send(mk(12, 0, 0, 0, -3, 2));
    send(mk(13, 5, 0, 0, 0, 7));
    send(mk(14, 0, 0, 7, 0, 0));
    send(mk(15, 0, 0, 0, 0, 0));
    wait_done();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wd_q.size() || wd_q[i] !== ed[i] || wa_q[i] !== 16'(16'h0100 + 2 * i)) begin
        errors++;
        $display("FAIL branch_word%0d: got %h want %h", i, (i < wd_q.size()) ? wd_q[i] : 16'hxxxx, ed[i]);
      end
    end
    checks++; if (to_cnt != 0) begin errors++; $display("FAIL branch_timeout: got %0d want 0", to_cnt); to_cnt = 0; end
  endtask

  task automatic test_backpressure();
    ins_t        v[6];
    logic [15:0] w[6];
    bit          lg;
    do_reset();
    mem_ready = 1'b0;
    do_start(16'h0200);
    for (int i = 0; i < 5; i++) v[i] = rand_legal();
    v[5] = mk(15, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) model(v[i], w[i], lg);
    for (int i = 0; i < 4; i++) send(v[i]);
    opcode = v[4].op; rs = v[4].rs; rt = v[4].rt; rd = v[4].rd; imm = v[4].imm; cc = v[4].cc;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", k, in_ready); end
      checks++;
      if (mem_wr_en !== 1'b1 || mem_addr !== 16'h0200 || mem_wdata !== w[0]) begin
        errors++;
        $display("FAIL bp_hold%0d: got en=%b %h@%h want en=1 %h@0200", k, mem_wr_en, mem_wdata, mem_addr, w[0]);
      end
    end
    mem_ready = 1'b1;
    send(v[4]);
    checks++; if (wa_q.size() < 1) begin errors++; $display("FAIL bp_fifth_order: got %0d writes want >=1", wa_q.size()); end
    send(v[5]);
    wait_done();
    checks++; if (wd_q.size() != 6) begin errors++; $display("FAIL bp_nwrites: got %0d want 6", wd_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= wd_q.size() || wd_q[i] !== w[i] || wa_q[i] !== 16'(16'h0200 + 2 * i)) begin
        errors++;
        $display("FAIL bp_write%0d: got %h want %h", i, (i < wd_q.size()) ? wd_q[i] : 16'hxxxx, w[i]);
      end
    end
    checks++; if (word_count !== 16'd6) begin errors++; $display("FAIL bp_count: got %0d want 6", word_count); end
    checks++; if (to_cnt != 0) begin errors++; $display("FAIL bp_timeout: got %0d want 0", to_cnt); to_cnt = 0; end
  endtask

  task automatic test_illegal();
    do_reset();
    mem_ready = 1'b1;
    do_start(16'h0300);
    send(mk(0, 1, 2, 3, 0, 0));
    tick(); tick(); tick();
    send(mk(8, 1, 2, 0, 8, 0));
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_lw_err: got %b want 1", err); end
    checks++;
    if (in_ready !== 1'b0 || mem_wr_en !== 1'b0) begin
      errors++; $display("FAIL ill_lw_idle: got rdy=%b en=%b want 0 0", in_ready, mem_wr_en);
    end
    tick(); tick();
    checks++;
    if (wd_q.size() != 1 || word_count !== 16'd1) begin
      errors++; $display("FAIL ill_lw_writes: got %0d/%0d want 1/1", wd_q.size(), word_count);
    end
    do_start(16'h0300);
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ill_restart: got err=%b rdy=%b want 0 1", err, in_ready);
    end
    send(mk(10, 0, 0, 4, 'h1FF, 0));
    tick(); tick();
    checks++;
    if (err !== 1'b1 || wd_q.size() != 1) begin
      errors++; $display("FAIL ill_llb: got err=%b writes=%0d want 1 1", err, wd_q.size());
    end
    do_start(16'h0300);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_clear: got %b want 0", err); end
    checks++; if (to_cnt != 0) begin errors++; $display("FAIL ill_timeout: got %0d want 0", to_cnt); to_cnt = 0; end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_ready = 1'b1;
    do_start(16'hFFFF);  // bit 0 must be dropped
    send(mk(1, 4, 5, 6, 0, 0));
    send(mk(15, 0, 0, 0, 0, 0));
    wait_done();
    checks++;
    if (wa_q.size() != 2 || wa_q[0] !== 16'hFFFE || wa_q[1] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_addrs: got n=%0d %h %h want FFFE 0000", wa_q.size(),
               (wa_q.size() > 0) ? wa_q[0] : 16'hxxxx, (wa_q.size() > 1) ? wa_q[1] : 16'hxxxx);
    end
    checks++; if (mem_addr !== 16'h0002) begin errors++; $display("FAIL wrap_next: got %h want 0002", mem_addr); end
    checks++; if (to_cnt != 0) begin errors++; $display("FAIL wrap_timeout: got %0d want 0", to_cnt); to_cnt = 0; end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_ready = 1'b0;
    do_start(16'h0400);
    for (int i = 0; i < 3; i++) send(rand_legal());
    checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL rmid_pending: got %b want 1", mem_wr_en); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (mem_wr_en !== 1'b0 || word_count !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL rmid_clear: got en=%b cnt=%0d %h@%h want 0 0 0000@0000",
               mem_wr_en, word_count, mem_wdata, mem_addr);
    end
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %b want 0", in_ready); end
    mem_ready = 1'b1;
    do_start(16'h0400);
    checks++;
    if (mem_wr_en !== 1'b0 || in_ready !== 1'b1 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL rmid_empty: got en=%b rdy=%b writes=%0d want 0 1 0", mem_wr_en, in_ready, wa_q.size());
    end
    checks++; if (to_cnt != 0) begin errors++; $display("FAIL rmid_timeout: got %0d want 0", to_cnt); to_cnt = 0; end
  endtask

  task automatic test_legality();
    logic [15:0] pool[12] = '{16'h0000, 16'h0007, 16'h0008, 16'h000F, 16'h0010, 16'h00FF,
                              16'h0100, 16'hFFFF, 16'hFFF8, 16'hFFF7, 16'hFF00, 16'hFEFF};
    ins_t        i;
    logic [15:0] w;
    bit          lg;
    for (int k = 0; k < 24; k++) begin
      do_reset();
      mem_ready = 1'b1;
      do_start(16'($urandom_range(0, 65535)));
      i = mk($urandom_range(4, 12), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 15), 0, $urandom_range(0, 7));
      i.imm = pool[$urandom_range(0, 11)];
      model(i, w, lg);
      send(i);
      tick(); tick();
      checks++;
      if (err !== !lg) begin
        errors++; $display("FAIL legal_err op=%h imm=%h: got %b want %b", i.op, i.imm, err, !lg);
      end
      checks++;
      if (lg ? (wd_q.size() != 1 || wd_q[0] !== w) : (wd_q.size() != 0)) begin
        errors++;
        $display("FAIL legal_word op=%h imm=%h: got n=%0d %h want legal=%b %h", i.op, i.imm,
                 wd_q.size(), (wd_q.size() > 0) ? wd_q[0] : 16'hxxxx, lg, w);
      end
    end
    checks++; if (to_cnt != 0) begin errors++; $display("FAIL legal_timeout: got %0d want 0", to_cnt); to_cnt = 0; end
  endtask

  task automatic test_random_stream();
    ins_t        i;
    logic [15:0] w;
    logic [15:0] exp_w[$];
    logic [15:0] b;
    bit          lg;
    int          n;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      exp_w.delete();
      b = 16'($urandom_range(0, 65535));
      do_start(b);
      rand_ready = 1'b1;
      n = $urandom_range(6, 12);
      for (int k = 0; k <= n; k++) begin
        i = (k == n) ? mk(15, 0, 0, 0, 0, 0) : rand_legal();
        model(i, w, lg);
        exp_w.push_back(w);
        send(i);
      end
      wait_done();
      rand_ready = 1'b0;
      checks++;
      if (wd_q.size() != exp_w.size() || word_count !== 16'(exp_w.size())) begin
        errors++;
        $display("FAIL rnd_count r%0d: got %0d/%0d want %0d", r, wd_q.size(), word_count, exp_w.size());
      end
      for (int k = 0; k < exp_w.size(); k++) begin
        checks++;
        if (k >= wd_q.size() || wd_q[k] !== exp_w[k] || wa_q[k] !== 16'((b & 16'hFFFE) + 2 * k)) begin
          errors++;
          $display("FAIL rnd_write r%0d k%0d: got %h@%h want %h@%h", r, k,
                   (k < wd_q.size()) ? wd_q[k] : 16'hxxxx, (k < wa_q.size()) ? wa_q[k] : 16'hxxxx,
                   exp_w[k], 16'((b & 16'hFFFE) + 2 * k));
        end
      end
    end
    checks++; if (to_cnt != 0) begin errors++; $display("FAIL rnd_timeout: got %0d want 0", to_cnt); to_cnt = 0; end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_branch();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_reset_mid();
    test_legality();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Sequential instruction assembler and loader for the WISC-S25 CPU.
- Accepts decoded instruction fields (opcode, rs, rt, rd, immediate, cc) over a valid/ready handshake and packs them into 16-bit machine words.
- Buffers the words in a small FIFO and writes them sequentially into instruction memory through a ready-gated write port.
- Used by testbenches and the boot path to build program images from field-level descriptions. Its output is the exact inverse of the team's field-level instruction display.

Parameters:
- FIFO_DEPTH, 4, number of encoded words buffered between the encoder and the memory port (power of two, ≥2).
- ADDR_W, 16, byte address width of the instruction memory port.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; latches base_addr, clears counters and error, and enters RUN.
- base_addr  input  ADDR_W  byte address of the first word (bit 0 ignored, treated as 0).
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  encoder can accept fields this cycle.
- opcode  input  4  instruction opcode.
- rs  input  4  source register.
- rt  input  4  second source register (store data register for SW).
- rd  input  4  destination register.
- imm  input  16  immediate or offset, two's complement where signed.
- cc  input  3  branch condition code.
- mem_wr_en  output  1  memory write request.
- mem_ready  input  1  memory accepts the write this cycle.
- mem_addr  output  ADDR_W  byte address of the write.
- mem_wdata  output  16  encoded instruction word.
- word_count  output  ADDR_W  number of words written since start.
- done  output  1  HLT word written; FIFO empty.
- err  output  1  sticky illegal-field error.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high. Ports are named clk and rst.
- Reset values:
  - in_ready=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, word_count=0, done=0, err=0.
  - FIFO empty, state IDLE.
- States: IDLE, RUN, DRAIN, DONE, ERR.
  - IDLE → RUN on start.
  - RUN → DRAIN on accepting an HLT (opcode F).
  - DRAIN → DONE when the HLT write completes.
  - RUN → ERR on an illegal accept.
  - start in DONE or ERR re-enters RUN. start in RUN or DRAIN is ignored.
  - rst in any state returns to IDLE, empties the FIFO, and clears all outputs.
- Accept rules:
  - in_ready = (state==RUN) && FIFO not full.
  - A transfer occurs when in_valid && in_ready. The encoded word enters the FIFO at the next clk edge (1-cycle latency).
- Encoding (word[15:12]=opcode):
  - 0,1,2,3,7: {op, rd, rs, rt}.
  - 4,5,6: {op, rd, rs, imm[3:0]}. Legal only if imm ≤ 15.
  - 8,9: {op, rt, rs, imm[3:0]}. Legal only if imm is in -8..7 (imm[15:3] all equal).
  - A,B: {op, rd, imm[7:0]}. Legal only if imm[15:8]==0.
  - C: {op, cc, imm[8:0]}. Legal only if imm is in -256..255.
  - D: {op, cc, 1'b0, rs, 4'h0}.
  - E: {op, rd, 8'h00}.
  - F: 16'hF000.
- Illegal field:
  - Nothing is enqueued. err=1, FIFO flushed, state ERR.
  - Words already written to memory are not retracted.
- Memory port:
  - mem_wr_en = FIFO not empty && state in {RUN, DRAIN}.
  - mem_wdata = FIFO head; mem_addr = current write address.
  - A write completes on mem_wr_en && mem_ready. On completion: pop the FIFO, mem_addr += 2, word_count += 1.
  - While mem_ready=0, mem_wdata and mem_addr hold stable.
- Wrap-around: mem_addr wraps from all-ones-minus-1 to 0 with no error.
- Simultaneous accept and write completion in the same cycle: push and pop both occur, and occupancy is unchanged. When full, in_ready stays 0 even if a pop completes that cycle (no combinational ready path from mem_ready).
- done:
  - Asserts the cycle after the HLT write completes and holds until start or rst.
  - in_ready=0 in DRAIN, DONE, and ERR.

Test Plan:
- start with base_addr=0x0010; stream ADD R3,R1,R2 / LLB R4,0x5A / HLT with mem_ready=1 → writes 0x0312@0x0010, 0xA45A@0x0012, 0xF000@0x0014; word_count=3; done=1 the cycle after the third write.
- Branch and PCS fields: B cc=3'b010 imm=-3; BR cc=3'b111 rs=5; PCS rd=7 → words 0xC5FD, 0xDE50, 0xE700.
- Backpressure: hold mem_ready=0, send 5 instructions with FIFO_DEPTH=4 → 4 accepted, in_ready=0 afterwards, mem_addr and mem_wdata stable; release mem_ready → in-order writes, 5th accepted after the first pop.
- Illegal immediates: LW imm=8, then (after restart) LLB imm=0x1FF → err=1, state ERR, no write for the offending word, in_ready=0; a subsequent start clears err.
- Wrap-around: base_addr=0xFFFE, two instructions → addresses 0xFFFE then 0x0000.
- Reset mid-operation: assert rst with 3 words queued and mem_ready=0 → next cycle mem_wr_en=0, FIFO empty, word_count=0, state IDLE.
